comp_stat_window: RTL and testbench

COMP_STAT_WINDOW -- requirements
Module: comp_stat_window

---
 rtl/comp_stat_window.sv | 111 +++++++++++
 tb/tb_comp_stat_window.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/comp_stat_window.sv
// Comparator statistics window.
// Collects WINDOW accepted comparator samples (one-hot Mayor/Igual/Menor flags), counts each
// class, flags non-one-hot samples, then holds a report until downstream accepts it.
// Ports:
//   i_Clk, i_Rst                  clock, synchronous active-high reset
//   i_Valid, o_Ready              sample handshake (upstream)
//   i_Mayor, i_Igual, i_Menor     comparator flags, expected one-hot
//   o_Valid, i_Ready              report handshake (downstream)
//   o_CntMayor/Igual/Menor        per-class counts of the reported window
//   o_Error                       reported window held at least one non-one-hot sample
module comp_stat_window #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned WINDOW = 16
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Valid,
  input  logic             i_Mayor,
  input  logic             i_Igual,
  input  logic             i_Menor,
  output logic             o_Ready,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [CNT_W-1:0] o_CntMayor,
  output logic [CNT_W-1:0] o_CntIgual,
  output logic [CNT_W-1:0] o_CntMenor,
  output logic             o_Error
);

  typedef enum logic [0:0] {StAcum, StReport} state_e;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WINDOW - 1);

  state_e           r_state, w_state_next;
  logic [CNT_W-1:0] r_smp_cnt;
  logic [CNT_W-1:0] r_cnt_mayor, r_cnt_igual, r_cnt_menor;
  logic             r_err;
  logic [CNT_W-1:0] r_out_mayor, r_out_igual, r_out_menor;
  logic             r_out_err;

  logic             w_accept, w_last, w_one_hot;
  logic [CNT_W-1:0] w_mayor_nxt, w_igual_nxt, w_menor_nxt;
  logic             w_err_nxt;

  // Window counters including the sample currently being accepted.
  always_comb begin
    w_one_hot   = $onehot({i_Mayor, i_Igual, i_Menor});
    w_accept    = i_Valid && (r_state == StAcum);
    w_last      = w_accept && (r_smp_cnt == LastIdx);
    w_mayor_nxt = r_cnt_mayor + CNT_W'(i_Mayor & w_one_hot);
    w_igual_nxt = r_cnt_igual + CNT_W'(i_Igual & w_one_hot);
    w_menor_nxt = r_cnt_menor + CNT_W'(i_Menor & w_one_hot);
    w_err_nxt   = r_err | ~w_one_hot;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StAcum:   if (w_last)  w_state_next = StReport;
      StReport: if (i_Ready) w_state_next = StAcum;
      default:  w_state_next = StAcum;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) r_state <= StAcum;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_smp_cnt   <= '0;
      r_cnt_mayor <= '0;
      r_cnt_igual <= '0;
      r_cnt_menor <= '0;
      r_err       <= 1'b0;
      r_out_mayor <= '0;
      r_out_igual <= '0;
      r_out_menor <= '0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      if (w_last) begin
        // Publish the completed window and start the next one from zero.
        r_out_mayor <= w_mayor_nxt;
        r_out_igual <= w_igual_nxt;
        r_out_menor <= w_menor_nxt;
        r_out_err   <= w_err_nxt;
        r_smp_cnt   <= '0;
        r_cnt_mayor <= '0;
        r_cnt_igual <= '0;
        r_cnt_menor <= '0;
        r_err       <= 1'b0;
      end else begin
        r_smp_cnt   <= r_smp_cnt + CNT_W'(1);
        r_cnt_mayor <= w_mayor_nxt;
        r_cnt_igual <= w_igual_nxt;
        r_cnt_menor <= w_menor_nxt;
        r_err       <= w_err_nxt;
      end
    end
  end

  // Handshake outputs decode state only, so neither depends combinationally on inputs.
  assign o_Ready    = (r_state == StAcum);
  assign o_Valid    = (r_state == StReport);
  assign o_CntMayor = r_out_mayor;
  assign o_CntIgual = r_out_igual;
  assign o_CntMenor = r_out_menor;
  assign o_Error    = r_out_err;

endmodule

// File: tb/tb_comp_stat_window.sv
// Self-checking bench for comp_stat_window: one WINDOW=4 and one WINDOW=1 instance share stimulus;
// each is compared every cycle against a window-list reference model.
module tb_comp_stat_window;

  logic       clk;
  logic       rst;
  logic       vld;
  logic [2:0] flg;  // {Mayor, Igual, Menor}
  logic       rdy;

  logic       rdy_o[2];
  logic       vld_o[2];
  logic [7:0] cm_o[2], ci_o[2], cl_o[2];
  logic       err_o[2];

  int checks   = 0;
  int failures = 0;

  comp_stat_window #(.CNT_W(8), .WINDOW(4)) u_dut4 (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(vld),
    .i_Mayor(flg[2]), .i_Igual(flg[1]), .i_Menor(flg[0]),
    .o_Ready(rdy_o[0]), .o_Valid(vld_o[0]), .i_Ready(rdy),
    .o_CntMayor(cm_o[0]), .o_CntIgual(ci_o[0]), .o_CntMenor(cl_o[0]), .o_Error(err_o[0])
  );

  comp_stat_window #(.CNT_W(8), .WINDOW(1)) u_dut1 (
    .i_Clk(clk), .i_Rst(rst), .i_Valid(vld),
    .i_Mayor(flg[2]), .i_Igual(flg[1]), .i_Menor(flg[0]),
    .o_Ready(rdy_o[1]), .o_Valid(vld_o[1]), .i_Ready(rdy),
    .o_CntMayor(cm_o[1]), .o_CntIgual(ci_o[1]), .o_CntMenor(cl_o[1]), .o_Error(err_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: list of samples in the open window plus the held report.
  int         win[2] = '{4, 1};
  int         len[2];
  logic [2:0] smp[2][16];
  bit         ev[2];
  int         ecm[2], eci[2], ecl[2];
  bit         eer[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model(input int k, input bit r, input bit v, input logic [2:0] f, input bit rd);
    if (r) begin
      ev[k] = 0; len[k] = 0; ecm[k] = 0; eci[k] = 0; ecl[k] = 0; eer[k] = 0;
    end else if (ev[k]) begin
      if (rd) ev[k] = 0;
    end else if (v) begin
      smp[k][len[k]] = f;
      len[k]++;
      if (len[k] == win[k]) begin
        ecm[k] = 0; eci[k] = 0; ecl[k] = 0; eer[k] = 0;
        for (int j = 0; j < win[k]; j++) begin
          case (smp[k][j])
            3'b100:  ecm[k]++;
            3'b010:  eci[k]++;
            3'b001:  ecl[k]++;
            default: eer[k] = 1;
          endcase
        end
        ev[k]  = 1;
        len[k] = 0;
      end
    end
  endtask

  // One clock: drive, advance, update model, compare both instances.
  task automatic step(input bit r, input bit v, input logic [2:0] f, input bit rd);
    rst = r; vld = v; flg = f; rdy = rd;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      model(k, r, v, f, rd);
      chk($sformatf("w%0d_valid", win[k]), 32'(vld_o[k]), 32'(ev[k]));
      chk($sformatf("w%0d_ready", win[k]), 32'(rdy_o[k]), 32'(!ev[k]));
      chk($sformatf("w%0d_mayor", win[k]), 32'(cm_o[k]),  32'(ecm[k]));
      chk($sformatf("w%0d_igual", win[k]), 32'(ci_o[k]),  32'(eci[k]));
      chk($sformatf("w%0d_menor", win[k]), 32'(cl_o[k]),  32'(ecl[k]));
      chk($sformatf("w%0d_error", win[k]), 32'(err_o[k]), 32'(eer[k]));
    end
  endtask

  localparam logic [2:0] M = 3'b100, I = 3'b010, L = 3'b001;

  initial begin
    int nrep;
    logic [2:0] f;
    rst = 1'b1; vld = 1'b0; flg = 3'b000; rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      len[k] = 0; ev[k] = 0; ecm[k] = 0; eci[k] = 0; ecl[k] = 0; eer[k] = 0;
    end

    step(1, 0, 0, 0);
    step(1, 1, M, 1);
    step(0, 0, 0, 0);

    // Basic window M,I,L,M with ready held
    step(0, 1, M, 1); step(0, 1, I, 1); step(0, 1, L, 1); step(0, 1, M, 1);
    chk("basic_report_mayor", 32'(cm_o[0]), 32'd2);
    step(0, 0, 0, 1); step(0, 0, 0, 1);

    // Back-pressure with valid held, then 4 Menor samples
    step(0, 1, M, 0); step(0, 1, M, 0); step(0, 1, M, 0); step(0, 1, M, 0);
    for (int c = 0; c < 10; c++) step(0, 1, L, 0);
    chk("bp_held_mayor", 32'(cm_o[0]), 32'd4);
    step(0, 1, L, 1);
    for (int c = 0; c < 4; c++) step(0, 1, L, 1);
    chk("bp_menor4", 32'(cl_o[0]), 32'd4);
    step(0, 0, 0, 1);

    // Error samples, then a clean window
    step(0, 1, M, 1); step(0, 1, 3'b000, 1); step(0, 1, 3'b110, 1); step(0, 1, I, 1);
    chk("err_flag", 32'(err_o[0]), 32'd1);
    step(0, 0, 0, 1);
    for (int c = 0; c < 4; c++) step(0, 1, I, 1);
    chk("clean_err", 32'(err_o[0]), 32'd0);
    step(0, 0, 0, 1);

    // Gaps with garbage flags on idle cycles
    step(0, 1, M, 1); step(0, 0, 3'b111, 1); step(0, 1, L, 1); step(0, 0, 3'b111, 1);
    step(0, 1, I, 1); step(0, 0, 3'b111, 1); step(0, 1, M, 1); step(0, 0, 3'b111, 1);

    // Reset mid-window, then 4 Igual; reset while a report is pending
    step(0, 1, M, 1); step(0, 1, M, 1); step(1, 1, M, 1);
    for (int c = 0; c < 4; c++) step(0, 1, I, 1);
    chk("rst_mid_igual", 32'(ci_o[0]), 32'd4);
    step(0, 0, 0, 1);
    for (int c = 0; c < 4; c++) step(0, 1, L, 0);
    step(1, 0, 0, 0);
    chk("rst_report_drop", 32'(vld_o[0]), 32'd0);
    step(0, 0, 0, 0);

    // WINDOW=1: 3 samples with ready held give 3 reports within 6 cycles
    nrep = 0;
    for (int c = 0; c < 6; c++) begin
      step(0, 1, I, 1);
      if (vld_o[1] === 1'b1) nrep++;
    end
    chk("w1_report_count", 32'(nrep), 32'd3);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      case ($urandom_range(0, 9))
        0:       f = 3'($urandom);
        1, 2, 3: f = M;
        4, 5, 6: f = I;
        default: f = L;
      endcase
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), f,
           ($urandom_range(0, 1) == 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
